clk_freq_monitor: RTL and testbench



---
 rtl/clk_freq_monitor.sv | 213 +++++++++++++++++++++
 tb/tb_clk_freq_monitor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor: measures the clk-cycle length of NUM_PER consecutive
// mon_in periods and reports pass / fail / timeout against EXP_PERIOD +/- TOL.
// Optional duty-cycle check and high_sum output: define CLK_MON_DUTY_EN.
`timescale 1ns/1ps

module clk_freq_monitor #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned NUM_PER    = 4,
    parameter int unsigned EXP_PERIOD = 4,
    parameter int unsigned TOL        = 0,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mon_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] period_sum
`ifdef CLK_MON_DUTY_EN
    ,
    output logic [CNT_W-1:0] high_sum
`endif
);

    localparam int unsigned EW   = CNT_W + 8;
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned EC_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [EW-1:0]    EXP_SUM  = EW'(NUM_PER * EXP_PERIOD);
    localparam logic [EW-1:0]    TOL_W    = EW'(TOL);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [EC_W-1:0]  EC_LAST  = EC_W'(NUM_PER - 1);
`ifdef CLK_MON_DUTY_EN
    localparam logic [EW-1:0]    DUTY_TOL = EW'(TOL + NUM_PER);
`endif

    logic [1:0]       state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] period_sum_q, period_sum_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [EC_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

    logic             rise;
    logic             sat;
    logic [CNT_W-1:0] cyc_inc;
    logic [CNT_W-1:0] sum_fin;
    logic [EW-1:0]    dev;
    logic             pass_ok;
`ifdef CLK_MON_DUTY_EN
    logic [CNT_W-1:0] high_sum_q, high_sum_d;
    logic [CNT_W-1:0] high_inc;
    logic [EW-1:0]    twice_high;
    logic [EW-1:0]    duty_dev;
`endif

    // Next-state, counters and result computation
    always_comb begin
        state_d      = state_q;
        s1_d         = mon_in;
        s2_d         = s1_q;
        s3_d         = s2_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        period_sum_d = period_sum_q;
        cyc_cnt_d    = cyc_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        to_cnt_d     = to_cnt_q;

        rise    = s2_q & ~s3_q;
        sat     = (cyc_cnt_q == CNT_MAX);
        cyc_inc = sat ? cyc_cnt_q : cyc_cnt_q + CNT_W'(1);
        sum_fin = sat ? CNT_MAX : cyc_cnt_q + CNT_W'(1);
        dev     = (EW'(sum_fin) >= EXP_SUM) ? (EW'(sum_fin) - EXP_SUM)
                                            : (EXP_SUM - EW'(sum_fin));
`ifdef CLK_MON_DUTY_EN
        high_sum_d = high_sum_q;
        high_inc   = (s2_q && (high_sum_q != CNT_MAX)) ? high_sum_q + CNT_W'(1) : high_sum_q;
        twice_high = EW'(high_inc) + EW'(high_inc);
        duty_dev   = (twice_high >= EW'(sum_fin)) ? (twice_high - EW'(sum_fin))
                                                  : (EW'(sum_fin) - twice_high);
        pass_ok    = (dev <= TOL_W) && !sat && (duty_dev <= DUTY_TOL);
`else
        pass_ok    = (dev <= TOL_W) && !sat;
`endif

        case (state_q)
            ST_IDLE: begin
                // busy stays high through the done cycle, so a start there is ignored
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    state_d      = ST_ARM;
                    busy_d       = 1'b1;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
                    period_sum_d = '0;
                    cyc_cnt_d    = '0;
                    edge_cnt_d   = '0;
                    to_cnt_d     = '0;
`ifdef CLK_MON_DUTY_EN
                    high_sum_d   = '0;
`endif
                end
            end
            ST_ARM: begin
                if (rise) begin
                    state_d    = ST_MEAS;
                    cyc_cnt_d  = '0;
                    edge_cnt_d = '0;
                    to_cnt_d   = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d      = ST_IDLE;
                    timeout_d    = 1'b1;
                    pass_d       = 1'b0;
                    period_sum_d = cyc_cnt_q;
                    done_d       = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_MEAS: begin
                cyc_cnt_d = cyc_inc;
`ifdef CLK_MON_DUTY_EN
                high_sum_d = high_inc;
`endif
                if (rise) begin
                    to_cnt_d = '0;
                    if (edge_cnt_q == EC_LAST) begin
                        state_d      = ST_IDLE;
                        period_sum_d = sum_fin;
                        pass_d       = pass_ok;
                        timeout_d    = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + EC_W'(1);
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d      = ST_IDLE;
                    timeout_d    = 1'b1;
                    pass_d       = 1'b0;
                    period_sum_d = cyc_cnt_q;
                    done_d       = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, synchroniser and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            period_sum_q <= '0;
            cyc_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            to_cnt_q     <= '0;
`ifdef CLK_MON_DUTY_EN
            high_sum_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            period_sum_q <= period_sum_d;
            cyc_cnt_q    <= cyc_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            to_cnt_q     <= to_cnt_d;
`ifdef CLK_MON_DUTY_EN
            high_sum_q   <= high_sum_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign period_sum = period_sum_q;
`ifdef CLK_MON_DUTY_EN
    assign high_sum   = high_sum_q;
`endif

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Scoreboard bench for clk_freq_monitor: expected results are queued at each
// start; a monitor pops and compares on every done pulse.
`timescale 1ns/1ps

module tb_clk_freq_monitor;

    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic             mon_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] period_sum;
`ifdef CLK_MON_DUTY_EN
    logic [CNT_W-1:0] high_sum;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] sum;
        logic             pass;
        logic             tmo;
        logic [CNT_W-1:0] high;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mode     = 0;   // 0: low, 1: 25 MHz 50%, 2: 50 MHz, 3: 25 MHz 25% duty

    clk_freq_monitor #(
        .CNT_W(CNT_W), .NUM_PER(4), .EXP_PERIOD(4), .TOL(0), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mon_in(mon_in),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .period_sum(period_sum)
`ifdef CLK_MON_DUTY_EN
        , .high_sum(high_sum)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // mon_in edges sit 2 ns past a 10 ns grid, well away from clk edges
    initial begin
        mon_in = 1'b0;
        #2;
        forever begin
            case (mode)
                1:       begin mon_in = 1'b1; #20; mon_in = 1'b0; #20; end
                2:       begin mon_in = 1'b1; #10; mon_in = 1'b0; #10; end
                3:       begin mon_in = 1'b1; #10; mon_in = 1'b0; #30; end
                default: begin mon_in = 1'b0; #10; end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int sum, input logic p, input logic t, input int high);
        exp_t e;
        e.sum  = CNT_W'(sum);
        e.pass = p;
        e.tmo  = t;
        e.high = CNT_W'(high);
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                check("busy_at_done", 32'(busy), 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no done, period_sum=%0d", period_sum);
                end else begin
                    e = exp_q.pop_front();
                    check("period_sum", 32'(period_sum), 32'(e.sum));
                    check("pass", 32'(pass), 32'(e.pass));
                    check("timeout", 32'(timeout), 32'(e.tmo));
`ifdef CLK_MON_DUTY_EN
                    check("high_sum", 32'(high_sum), 32'(e.high));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_period_sum", 32'(period_sum), 32'd0);
        rst = 1'b0;

        // 25 MHz, nominal
        mode = 1;
        repeat (10) @(negedge clk);
        push_exp(16, 1'b1, 1'b0, 8);
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        wait_done(200, "t1_done");
        @(negedge clk);
        check("t1_busy_clear", 32'(busy), 32'd0);

        // 50 MHz, too fast
        mode = 2;
        repeat (10) @(negedge clk);
        push_exp(8, 1'b0, 1'b0, 4);
        pulse_start();
        wait_done(200, "t2_done");

        // held low: timeout exactly 64 cycles after ARM entry
        mode = 0;
        repeat (10) @(negedge clk);
        push_exp(0, 1'b0, 1'b1, 0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cnt = 0;
        while (!done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("t3_timeout_latency", 32'(cnt), 32'd64);
        @(negedge clk);
        check("t3_busy_clear", 32'(busy), 32'd0);

        // reset in the middle of MEASURE aborts without a done pulse
        mode = 1;
        repeat (10) @(negedge clk);
        pulse_start();
        repeat (12) @(negedge clk);
        check("t4_busy_mid", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #0.5;
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_done", 32'(done), 32'd0);
        check("t4_rst_pass", 32'(pass), 32'd0);
        check("t4_rst_timeout", 32'(timeout), 32'd0);
        check("t4_rst_period_sum", 32'(period_sum), 32'd0);
        #0.5 rst = 1'b0;
        repeat (40) @(negedge clk);
        check("t4_idle_after_rst", 32'(busy), 32'd0);
        push_exp(16, 1'b1, 1'b0, 8);
        pulse_start();
        wait_done(200, "t4_done");

        // extra starts during a run and at done are ignored; results held
        repeat (5) @(negedge clk);
        push_exp(16, 1'b1, 1'b0, 8);
        pulse_start();
        repeat (3) begin
            repeat (2) @(negedge clk);
            pulse_start();
        end
        wait_done(200, "t5_done");
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("t5_start_at_done_ignored", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check("t5_hold_sum", 32'(period_sum), 32'd16);
        check("t5_hold_pass", 32'(pass), 32'd1);
        check("t5_hold_timeout", 32'(timeout), 32'd0);
        push_exp(16, 1'b1, 1'b0, 8);
        pulse_start();
        check("t5_clear_sum", 32'(period_sum), 32'd0);
        check("t5_clear_pass", 32'(pass), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        wait_done(200, "t5_done2");

        // 25% duty at correct frequency: fails only when the duty check exists
        mode = 3;
        repeat (10) @(negedge clk);
`ifdef CLK_MON_DUTY_EN
        push_exp(16, 1'b0, 1'b0, 4);
`else
        push_exp(16, 1'b1, 1'b0, 4);
`endif
        pulse_start();
        wait_done(200, "t6_done");

        repeat (20) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
